// File: rtl/npc_btb.sv
// Next-PC generator: owns the fetch PC and a direct-mapped BTB with 2-bit counters,
// resolves execute-stage control flow and redirects fetch on a misprediction.
module npc_btb #(
    parameter int              XLEN        = 32,
    parameter int              BTB_ENTRIES = 16,
    parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    output logic [XLEN-1:0] pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [1:0]      ex_npc_op,
    input  logic            ex_br,
    input  logic [XLEN-1:0] ex_offset,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic [XLEN-1:0] pcb,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     br_cnt,
    output logic [31:0]     mis_cnt
);
    localparam int IDX  = $clog2(BTB_ENTRIES);
    localparam int TAGW = XLEN - IDX - 2;

    localparam logic [1:0] OP_PC4     = 2'b00;
    localparam logic [1:0] OP_BRC     = 2'b01;
    localparam logic [1:0] OP_JMP     = 2'b10;
    localparam logic [1:0] OP_PC4_ADD = 2'b11;

    logic            btb_valid  [BTB_ENTRIES];
    logic [TAGW-1:0] btb_tag    [BTB_ENTRIES];
    logic [XLEN-1:0] btb_target [BTB_ENTRIES];
    logic [1:0]      btb_ctr    [BTB_ENTRIES];

    logic [IDX-1:0]  lk_idx;
    logic [TAGW-1:0] lk_tag;
    logic            lk_hit;
    logic [XLEN-1:0] pc_plus4;

    logic [IDX-1:0]  ex_idx;
    logic [TAGW-1:0] ex_tag;
    logic            ex_hit;
    logic            act_taken;
    logic [XLEN-1:0] ex_plus4;
    logic [XLEN-1:0] ex_plus_off;
    logic [XLEN-1:0] act_next;
    logic            upd;

    // Fetch-side lookup reads the table asynchronously, so a same-cycle write is not yet visible.
    always_comb begin
        lk_idx      = pc[IDX+1:2];
        lk_tag      = pc[XLEN-1:IDX+2];
        pc_plus4    = pc + XLEN'(4);
        lk_hit      = btb_valid[lk_idx] && (btb_tag[lk_idx] == lk_tag);
        pred_taken  = lk_hit && btb_ctr[lk_idx][1];
        pred_target = lk_hit ? btb_target[lk_idx] : pc_plus4;
    end

    // A stale alias on a PC4/PC4_ADD op has act_taken=0, so it redirects to ex_pc+4 naturally.
    always_comb begin
        ex_idx      = ex_pc[IDX+1:2];
        ex_tag      = ex_pc[XLEN-1:IDX+2];
        ex_hit      = btb_valid[ex_idx] && (btb_tag[ex_idx] == ex_tag);
        ex_plus4    = ex_pc + XLEN'(4);
        ex_plus_off = ex_pc + ex_offset;
        act_taken   = (ex_npc_op == OP_JMP) || ((ex_npc_op == OP_BRC) && ex_br);
        act_next    = act_taken ? ex_plus_off : ex_plus4;
        redirect    = ex_valid && ((ex_pred_taken != act_taken) ||
                                   (act_taken && (ex_pred_target != act_next)));
        redirect_pc = act_next;
        pcb         = (ex_npc_op == OP_PC4_ADD) ? ex_plus_off : ex_plus4;
        upd         = ex_valid && ((ex_npc_op == OP_BRC) || (ex_npc_op == OP_JMP));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= RESET_PC;
            br_cnt  <= '0;
            mis_cnt <= '0;
        end else begin
            if (redirect)
                pc <= redirect_pc;
            else if (!stall)
                pc <= pred_taken ? pred_target : pc_plus4;
            if (upd && (br_cnt != '1))
                br_cnt <= br_cnt + 32'd1;
            if (redirect && (mis_cnt != '1))
                mis_cnt <= mis_cnt + 32'd1;
        end
    end

    // Hits train the counter; only a taken miss allocates, starting weakly taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_valid[i]  <= 1'b0;
                btb_tag[i]    <= '0;
                btb_target[i] <= '0;
                btb_ctr[i]    <= 2'b01;
            end
        end else if (upd) begin
            if (ex_hit) begin
                if (act_taken) begin
                    btb_target[ex_idx] <= act_next;
                    if (btb_ctr[ex_idx] != 2'b11)
                        btb_ctr[ex_idx] <= btb_ctr[ex_idx] + 2'd1;
                end else if (btb_ctr[ex_idx] != 2'b00) begin
                    btb_ctr[ex_idx] <= btb_ctr[ex_idx] - 2'd1;
                end
            end else if (act_taken) begin
                btb_valid[ex_idx]  <= 1'b1;
                btb_tag[ex_idx]    <= ex_tag;
                btb_target[ex_idx] <= act_next;
                btb_ctr[ex_idx]    <= 2'b10;
            end
        end
    end

    logic unused_op_pc4;
    assign unused_op_pc4 = (ex_npc_op == OP_PC4);
endmodule

// File: tb/tb_npc_btb.sv
// Directed bench for npc_btb: reset sequencing, JMP/BRC resolution, counter training,
// aliasing, pcb generation, stall/redirect priority, PC wrap and reset override.
module tb_npc_btb;
    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [1:0]  ex_npc_op;
    logic        ex_br;
    logic [31:0] ex_offset;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic [31:0] pcb;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] br_cnt;
    logic [31:0] mis_cnt;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_br = 0;
    logic [31:0] exp_mis = 0;

    npc_btb #(.XLEN(32), .BTB_ENTRIES(16), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .stall(stall), .pc(pc), .pred_taken(pred_taken),
        .pred_target(pred_target), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_npc_op(ex_npc_op), .ex_br(ex_br), .ex_offset(ex_offset),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .pcb(pcb), .redirect(redirect), .redirect_pc(redirect_pc),
        .br_cnt(br_cnt), .mis_cnt(mis_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ex(input logic v, input logic [31:0] p, input logic [1:0] op,
                            input logic b, input logic [31:0] off, input logic pt,
                            input logic [31:0] ptg);
        ex_valid = v; ex_pc = p; ex_npc_op = op; ex_br = b;
        ex_offset = off; ex_pred_taken = pt; ex_pred_target = ptg;
        #1;
    endtask

    task automatic idle_ex();
        drive_ex(1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    // Stale-alias PC4 at target-4 is used to steer the fetch PC to a chosen address.
    task automatic force_pc(input logic [31:0] target);
        drive_ex(1'b1, target - 32'd4, 2'b00, 1'b0, 32'h0, 1'b1, target);
        step();
        exp_mis++;
        idle_ex();
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; idle_ex();
        step(); step();
        rst = 1'b0; #1;
        vectors++; if (pc !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_pc: got %h want %h", pc, 32'h0); end
        vectors++; if (pred_taken !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_pred_taken: got %b want 0", pred_taken); end
        vectors++; if (pred_target !== 32'h4) begin miscompares++; $display("[TB] FAIL reset_pred_target: got %h want %h", pred_target, 32'h4); end
        vectors++; if (br_cnt !== 32'h0 || mis_cnt !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_counters: got %h/%h want 0/0", br_cnt, mis_cnt); end
        for (int i = 1; i <= 3; i++) begin
            step();
            vectors++; if (pc !== 32'(4 * i) || pred_taken !== 1'b0) begin miscompares++; $display("[TB] FAIL seq_pc%0d: got %h/%b want %h/0", i, pc, pred_taken, 32'(4 * i)); end
        end
        stall = 1'b1; #1;
    endtask

    task automatic test_jmp();
        drive_ex(1'b1, 32'h10, 2'b10, 1'b0, 32'h40, 1'b0, 32'h14);
        vectors++; if (redirect !== 1'b1 || redirect_pc !== 32'h50) begin miscompares++; $display("[TB] FAIL jmp_redirect: got %b/%h want 1/%h", redirect, redirect_pc, 32'h50); end
        vectors++; if (pcb !== 32'h14) begin miscompares++; $display("[TB] FAIL jmp_pcb: got %h want %h", pcb, 32'h14); end
        step(); exp_br++; exp_mis++; idle_ex();
        vectors++; if (pc !== 32'h50) begin miscompares++; $display("[TB] FAIL jmp_next_pc: got %h want %h", pc, 32'h50); end
        vectors++; if (br_cnt !== exp_br || mis_cnt !== exp_mis) begin miscompares++; $display("[TB] FAIL jmp_counters: got %h/%h want %h/%h", br_cnt, mis_cnt, exp_br, exp_mis); end
        vectors++; if (pred_taken !== 1'b0 || pred_target !== 32'h54) begin miscompares++; $display("[TB] FAIL alias_0x50: got %b/%h want 0/%h", pred_taken, pred_target, 32'h54); end
        force_pc(32'h10);
        vectors++; if (pred_taken !== 1'b1 || pred_target !== 32'h50) begin miscompares++; $display("[TB] FAIL jmp_predict: got %b/%h want 1/%h", pred_taken, pred_target, 32'h50); end
        vectors++; if (br_cnt !== exp_br) begin miscompares++; $display("[TB] FAIL pc4_no_brcnt: got %h want %h", br_cnt, exp_br); end
        stall = 1'b0; step(); stall = 1'b1; #1;
        vectors++; if (pc !== 32'h50) begin miscompares++; $display("[TB] FAIL jmp_follow_pred: got %h want %h", pc, 32'h50); end
    endtask

    task automatic test_brc_not_taken();
        drive_ex(1'b1, 32'h20, 2'b01, 1'b0, 32'h8, 1'b0, 32'h24);
        vectors++; if (redirect !== 1'b0) begin miscompares++; $display("[TB] FAIL brc_nt_redirect: got %b want 0", redirect); end
        step(); exp_br++; idle_ex();
        vectors++; if (br_cnt !== exp_br || mis_cnt !== exp_mis) begin miscompares++; $display("[TB] FAIL brc_nt_counters: got %h/%h want %h/%h", br_cnt, mis_cnt, exp_br, exp_mis); end
        force_pc(32'h20);
        vectors++; if (pc !== 32'h20 || pred_taken !== 1'b0) begin miscompares++; $display("[TB] FAIL brc_nt_noalloc: got %h/%b want %h/0", pc, pred_taken, 32'h20); end
    endtask

    task automatic test_brc_counter();
        drive_ex(1'b1, 32'h30, 2'b01, 1'b1, 32'hFFFF_FFF0, 1'b0, 32'h34);
        vectors++; if (redirect !== 1'b1 || redirect_pc !== 32'h20) begin miscompares++; $display("[TB] FAIL brc_first: got %b/%h want 1/%h", redirect, redirect_pc, 32'h20); end
        step(); exp_br++; exp_mis++;
        for (int i = 0; i < 2; i++) begin
            drive_ex(1'b1, 32'h30, 2'b01, 1'b1, 32'hFFFF_FFF0, 1'b1, 32'h20);
            vectors++; if (redirect !== 1'b0) begin miscompares++; $display("[TB] FAIL brc_taken%0d: got %b want 0", i, redirect); end
            step(); exp_br++;
        end
        drive_ex(1'b1, 32'h30, 2'b01, 1'b0, 32'hFFFF_FFF0, 1'b1, 32'h20);
        vectors++; if (redirect !== 1'b1 || redirect_pc !== 32'h34 || pcb !== 32'h34) begin miscompares++; $display("[TB] FAIL brc_mispredict: got %b/%h/%h want 1/%h/%h", redirect, redirect_pc, pcb, 32'h34, 32'h34); end
        step(); exp_br++; exp_mis++; idle_ex();
        vectors++; if (pc !== 32'h34) begin miscompares++; $display("[TB] FAIL brc_redirect_pc: got %h want %h", pc, 32'h34); end
        force_pc(32'h30);
        vectors++; if (pred_taken !== 1'b1 || pred_target !== 32'h20) begin miscompares++; $display("[TB] FAIL brc_ctr10: got %b/%h want 1/%h", pred_taken, pred_target, 32'h20); end
        drive_ex(1'b1, 32'h30, 2'b01, 1'b0, 32'hFFFF_FFF0, 1'b0, 32'h34);
        vectors++; if (pred_taken !== 1'b1 || redirect !== 1'b0) begin miscompares++; $display("[TB] FAIL brc_prewrite: got %b/%b want 1/0", pred_taken, redirect); end
        step(); exp_br++; idle_ex();
        vectors++; if (pc !== 32'h30 || pred_taken !== 1'b0) begin miscompares++; $display("[TB] FAIL brc_ctr01: got %h/%b want %h/0", pc, pred_taken, 32'h30); end
        vectors++; if (br_cnt !== exp_br || mis_cnt !== exp_mis) begin miscompares++; $display("[TB] FAIL brc_counters: got %h/%h want %h/%h", br_cnt, mis_cnt, exp_br, exp_mis); end
    endtask

    task automatic test_pc4_add();
        drive_ex(1'b1, 32'h40, 2'b11, 1'b0, 32'h1000, 1'b0, 32'h44);
        vectors++; if (pcb !== 32'h1040 || redirect !== 1'b0) begin miscompares++; $display("[TB] FAIL pc4add_pcb: got %h/%b want %h/0", pcb, redirect, 32'h1040); end
        step();
        drive_ex(1'b0, 32'h40, 2'b11, 1'b0, 32'h1000, 1'b0, 32'h44);
        vectors++; if (pcb !== 32'h1040) begin miscompares++; $display("[TB] FAIL pcb_invalid: got %h want %h", pcb, 32'h1040); end
        idle_ex();
        vectors++; if (br_cnt !== exp_br) begin miscompares++; $display("[TB] FAIL pc4add_brcnt: got %h want %h", br_cnt, exp_br); end
        force_pc(32'h40);
        vectors++; if (pred_taken !== 1'b0 || pred_target !== 32'h44) begin miscompares++; $display("[TB] FAIL pc4add_nobtb: got %b/%h want 0/%h", pred_taken, pred_target, 32'h44); end
    endtask

    task automatic test_wrap();
        drive_ex(1'b1, 32'h100, 2'b10, 1'b0, 32'hFFFF_FEFC, 1'b0, 32'h104);
        vectors++; if (redirect_pc !== 32'hFFFF_FFFC) begin miscompares++; $display("[TB] FAIL wrap_target: got %h want %h", redirect_pc, 32'hFFFF_FFFC); end
        step(); exp_br++; exp_mis++; idle_ex();
        stall = 1'b0; step(); stall = 1'b1; #1;
        vectors++; if (pc !== 32'h0) begin miscompares++; $display("[TB] FAIL wrap_pc: got %h want %h", pc, 32'h0); end
    endtask

    task automatic test_stall_redirect();
        drive_ex(1'b1, 32'h70, 2'b10, 1'b0, 32'h10, 1'b0, 32'h74);
        step(); exp_br++; exp_mis++; idle_ex();
        vectors++; if (pc !== 32'h80) begin miscompares++; $display("[TB] FAIL stall_redirect: got %h want %h", pc, 32'h80); end
        vectors++; if (br_cnt !== exp_br || mis_cnt !== exp_mis) begin miscompares++; $display("[TB] FAIL final_counters: got %h/%h want %h/%h", br_cnt, mis_cnt, exp_br, exp_mis); end
        rst = 1'b1;
        drive_ex(1'b1, 32'h70, 2'b10, 1'b0, 32'h10, 1'b0, 32'h74);
        step(); rst = 1'b0; idle_ex();
        exp_br = 0; exp_mis = 0;
        vectors++; if (pc !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_override_pc: got %h want %h", pc, 32'h0); end
        vectors++; if (br_cnt !== 32'h0 || mis_cnt !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_counters: got %h/%h want 0/0", br_cnt, mis_cnt); end
        force_pc(32'h10);
        vectors++; if (pred_taken !== 1'b0 || pred_target !== 32'h14) begin miscompares++; $display("[TB] FAIL rst_btb_clear: got %b/%h want 0/%h", pred_taken, pred_target, 32'h14); end
        force_pc(32'h70);
        vectors++; if (pred_taken !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_no_update: got %b want 0", pred_taken); end
    endtask

    initial begin
        test_reset();
        test_jmp();
        test_brc_not_taken();
        test_brc_counter();
        test_pc4_add();
        test_wrap();
        test_stall_redirect();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
